// File: rtl/hps_rst_pkg.sv
// Shared encodings for the HPS reset-request sequencer: cause codes, FSM states, ISSP bit indices.
package hps_rst_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_COLD  = 2'd1,
        CAUSE_WARM  = 2'd2,
        CAUSE_DEBUG = 2'd3
    } cause_e;

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StWaitAck,
        StWaitRel,
        StHoldoff
    } state_e;

    localparam int unsigned IdxCold  = 0;
    localparam int unsigned IdxWarm  = 1;
    localparam int unsigned IdxDebug = 2;

    // Fixed priority cold > warm > debug; returns a one-hot grant.
    function automatic logic [2:0] pick_grant(input logic [2:0] pending);
        logic [2:0] g;
        g = '0;
        if (pending[IdxCold]) begin
            g[IdxCold] = 1'b1;
        end else if (pending[IdxWarm]) begin
            g[IdxWarm] = 1'b1;
        end else if (pending[IdxDebug]) begin
            g[IdxDebug] = 1'b1;
        end
        return g;
    endfunction

    function automatic cause_e cause_of(input logic [2:0] grant);
        cause_e c;
        c = CAUSE_NONE;
        if (grant[IdxCold]) begin
            c = CAUSE_COLD;
        end else if (grant[IdxWarm]) begin
            c = CAUSE_WARM;
        end else if (grant[IdxDebug]) begin
            c = CAUSE_DEBUG;
        end
        return c;
    endfunction

endpackage

// File: rtl/pb_debouncer.sv
// Pushbutton synchroniser and debouncer: one press pulse per accepted press, release re-arms.
module pb_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pb_n_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pressed_q, pressed_d;
    logic            press_q, press_d;

    always_comb begin
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        if (sync_q[1]) begin
            cnt_d     = '0;
            pressed_d = 1'b0;
        end else if (!pressed_q) begin
            if (cnt_q == CntLast) begin
                pressed_d = 1'b1;
                press_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= 2'b11;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pb_n_i};
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/hps_reset_req_sequencer.sv
// Serialises cold/warm/debug HPS reset requests onto the f2h_*_reset_req_n pins, one at a time.
module hps_reset_req_sequencer
    import hps_rst_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES    = 16,
    parameter int unsigned ACK_TIMEOUT     = 50_000_000,
    parameter int unsigned HOLDOFF_CYCLES  = 1024,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic [2:0]       issp_req,
    input  logic             pb_n,
    input  logic             h2f_reset_n,
    input  logic             clr_err,
    output logic             f2h_cold_req_n,
    output logic             f2h_warm_req_n,
    output logic             f2h_debug_req_n,
    output logic             busy,
    output logic [1:0]       last_cause,
    output logic             timeout_err,
    output logic [CNT_W-1:0] req_count
);

    localparam int unsigned PulseW = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned AckW   = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned HoldW  = $clog2(HOLDOFF_CYCLES + 1);
    localparam int unsigned CntW   = (PulseW > AckW) ? ((PulseW > HoldW) ? PulseW : HoldW)
                                                     : ((AckW > HoldW) ? AckW : HoldW);
    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] AckLast   = CntW'(ACK_TIMEOUT - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(HOLDOFF_CYCLES - 1);

    logic             pb_press;
    logic [1:0]       h2f_sync_q;
    logic [2:0]       issp_s_q, issp_prev_q;
    logic [2:0]       req_in;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       req_n_q, req_n_d;
    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    cause_e           last_cause_q, last_cause_d;
    logic [CNT_W-1:0] req_count_q, req_count_d;
    logic             timeout_err_q, timeout_err_d;
    logic             set_err;

    pb_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pb_debouncer (
        .clk_i  (sys_clk),
        .rst_i  (sys_reset),
        .pb_n_i (pb_n),
        .press_o(pb_press)
    );

    always_comb begin
        req_in          = issp_s_q & ~issp_prev_q;
        req_in[IdxWarm] = req_in[IdxWarm] | pb_press;

        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        pending_d    = pending_q | req_in;
        last_cause_d = last_cause_q;
        req_count_d  = req_count_q;
        set_err      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pending_q != 3'b000) begin
                    grant_d = pick_grant(pending_q);
                    // A same-type edge arriving in the grant cycle is absorbed by this grant.
                    pending_d    = pending_d & ~grant_d;
                    state_d      = StAssert;
                    cnt_d        = '0;
                    last_cause_d = cause_of(grant_d);
                    if (req_count_q != '1) begin
                        req_count_d = req_count_q + CNT_W'(1);
                    end
                end
            end
            StAssert: begin
                if (cnt_q == PulseLast) begin
                    cnt_d   = '0;
                    state_d = grant_q[IdxDebug] ? StHoldoff : StWaitAck;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitAck: begin
                if (!h2f_sync_q[1]) begin
                    state_d = StWaitRel;
                end else if (cnt_q == AckLast) begin
                    set_err = 1'b1;
                    cnt_d   = '0;
                    state_d = StHoldoff;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitRel: begin
                if (h2f_sync_q[1]) begin
                    cnt_d   = '0;
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if (cnt_q == HoldLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        req_n_d       = (state_d == StAssert) ? ~grant_d : 3'b111;
        timeout_err_d = set_err | (timeout_err_q & ~clr_err);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            h2f_sync_q    <= 2'b11;
            issp_s_q      <= 3'b111;
            issp_prev_q   <= 3'b111;
            pending_q     <= 3'b000;
            grant_q       <= 3'b000;
            req_n_q       <= 3'b111;
            state_q       <= StIdle;
            cnt_q         <= '0;
            last_cause_q  <= CAUSE_NONE;
            req_count_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            h2f_sync_q    <= {h2f_sync_q[0], h2f_reset_n};
            issp_s_q      <= issp_req;
            issp_prev_q   <= issp_s_q;
            pending_q     <= pending_d;
            grant_q       <= grant_d;
            req_n_q       <= req_n_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_cause_q  <= last_cause_d;
            req_count_q   <= req_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign f2h_cold_req_n  = req_n_q[IdxCold];
    assign f2h_warm_req_n  = req_n_q[IdxWarm];
    assign f2h_debug_req_n = req_n_q[IdxDebug];
    assign busy            = (state_q != StIdle);
    assign last_cause      = last_cause_q;
    assign timeout_err     = timeout_err_q;
    assign req_count       = req_count_q;

endmodule

// File: tb/tb_hps_reset_req_sequencer.sv
// Directed plus randomised bench: pulses are captured by a monitor and compared to a priority model.
module tb_hps_reset_req_sequencer;

    localparam int PULSE = 4;
    localparam int ACK   = 50;
    localparam int HOLD  = 8;
    localparam int DEB   = 10;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          sys_clk = 1'b0;
    logic          sys_reset = 1'b1;
    logic [2:0]    issp_req = 3'b000;
    logic          pb_n = 1'b1;
    logic          h2f_reset_n = 1'b1;
    logic          clr_err = 1'b0;
    logic          f2h_cold_req_n, f2h_warm_req_n, f2h_debug_req_n;
    logic          busy, timeout_err;
    logic [1:0]    last_cause;
    logic [CW-1:0] req_count;

    hps_reset_req_sequencer #(
        .PULSE_CYCLES   (PULSE),
        .ACK_TIMEOUT    (ACK),
        .HOLDOFF_CYCLES (HOLD),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .issp_req       (issp_req),
        .pb_n           (pb_n),
        .h2f_reset_n    (h2f_reset_n),
        .clr_err        (clr_err),
        .f2h_cold_req_n (f2h_cold_req_n),
        .f2h_warm_req_n (f2h_warm_req_n),
        .f2h_debug_req_n(f2h_debug_req_n),
        .busy           (busy),
        .last_cause     (last_cause),
        .timeout_err    (timeout_err),
        .req_count      (req_count)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int start;
        int stop;
    } pulse_t;

    pulse_t     obs_q[$];
    int         exp_q[$];
    int         exp_count = 0;
    int         exp_cause = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cur_start[3];
    int         overlap_seen = 0;
    int         busy_fall = -1;
    int         h2f_rise = -1;
    int         ack_en = 1;
    int         ack_dly = 5;
    int         ack_len = 20;
    int         ack_lo_at = -1;
    int         ack_hi_at = -1;
    logic [2:0] prev_n = 3'b111;
    logic       busy_prev = 1'b0;

    // Pulse monitor plus HPS model: after each cold/warm pulse, drop h2f_reset_n for a while.
    always @(negedge sys_clk) begin
        logic [2:0] now_n;
        now_n = {f2h_debug_req_n, f2h_warm_req_n, f2h_cold_req_n};
        if ($countones(~now_n) > 1) overlap_seen++;
        for (int i = 0; i < 3; i++) begin
            if (prev_n[i] && !now_n[i]) cur_start[i] = cyc;
            if (!prev_n[i] && now_n[i]) begin
                obs_q.push_back('{kind: i + 1, start: cur_start[i], stop: cyc});
                if (i < 2 && ack_en != 0) begin
                    ack_lo_at = cyc + ack_dly;
                    ack_hi_at = cyc + ack_dly + ack_len;
                end
            end
        end
        prev_n = now_n;
        if (cyc == ack_lo_at) h2f_reset_n = 1'b0;
        if (cyc == ack_hi_at) begin
            h2f_reset_n = 1'b1;
            h2f_rise = cyc;
        end
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    // Model: requests seen together while idle are served strictly cold, warm, debug.
    task automatic expect_mask(input logic [2:0] m);
        for (int i = 0; i < 3; i++) begin
            if (m[i]) begin
                exp_q.push_back(i + 1);
                exp_cause = i + 1;
                if (exp_count < CMAX) exp_count++;
            end
        end
    endtask

    task automatic issp_edge(input logic [2:0] m);
        issp_req = m;
        step();
        issp_req = 3'b000;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int k = 0;
        while ((obs_q.size() < n || busy) && k < budget) begin
            step();
            k++;
        end
        chk({tag, " completes in budget"}, k < budget, 1);
    endtask

    task automatic wait_obs(input string tag, input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({tag, " pulse seen in budget"}, k < budget, 1);
    endtask

    task automatic check_pulses(input string tag);
        chk({tag, " pulse count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, " pulse kind"}, obs_q[i].kind, exp_q[i]);
            chk({tag, " pulse width"}, obs_q[i].stop - obs_q[i].start, PULSE);
            if (i > 0) chk({tag, " no overlap"}, obs_q[i].start > obs_q[i - 1].stop, 1);
        end
        chk({tag, " req_count"}, req_count, exp_count);
        chk({tag, " last_cause"}, last_cause, exp_cause);
        chk({tag, " one req at a time"}, overlap_seen, 0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int k0;
        int e;
        int k;
        logic [2:0] m;
        int glitch[3] = '{3, 7, 9};

        // Reset values
        repeat (3) step();
        chk("rst req_n", {f2h_debug_req_n, f2h_warm_req_n, f2h_cold_req_n}, 3'b111);
        chk("rst busy", busy, 0);
        chk("rst last_cause", last_cause, 0);
        chk("rst timeout_err", timeout_err, 0);
        chk("rst req_count", req_count, 0);
        sys_reset = 1'b0;
        repeat (3) step();

        // 1: single cold request, HPS acknowledges
        k0 = cyc;
        issp_edge(3'b001);
        expect_mask(3'b001);
        wait_done("t1", 1, 300);
        chk("t1 latency", obs_q[0].start, k0 + 3);
        // two sync flops plus one transition into holdoff, then HOLD cycles
        chk("t1 busy after ack release", busy_fall, h2f_rise + 3 + HOLD);
        check_pulses("t1");

        // 2: all three at once, then random batches
        issp_edge(3'b111);
        expect_mask(3'b111);
        wait_done("t2", 3, 1000);
        chk("t2 debug skips ack wait", busy_fall, obs_q[2].stop + HOLD);
        check_pulses("t2");
        for (int r = 0; r < 4; r++) begin
            m = 3'($urandom_range(1, 7));
            ack_dly = $urandom_range(1, 10);
            ack_len = $urandom_range(1, 15);
            issp_edge(m);
            expect_mask(m);
            wait_done("t2r", $countones(m), 1000);
            check_pulses("t2r");
        end
        ack_dly = 5;
        ack_len = 20;

        // 3: warm request never acknowledged
        ack_en = 0;
        issp_edge(3'b010);
        expect_mask(3'b010);
        wait_obs("t3", 1, 100);
        e = obs_q[0].stop;
        while (cyc < e + ACK - 1) step();
        chk("t3 err before timeout", timeout_err, 0);
        step();
        chk("t3 err at timeout", timeout_err, 1);
        wait_done("t3", 1, 100);
        chk("t3 idle after holdoff", busy_fall, e + ACK + HOLD);
        check_pulses("t3");
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t3 clr_err clears", timeout_err, 0);
        issp_edge(3'b010);
        expect_mask(3'b010);
        wait_obs("t3b", 1, 100);
        e = obs_q[0].stop;
        while (cyc < e + ACK - 1) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t3 set beats clr", timeout_err, 1);
        wait_done("t3b", 1, 100);
        check_pulses("t3b");
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t3 clr again", timeout_err, 0);

        // 4: pushbutton glitches and presses
        ack_en = 1;
        for (int g = 0; g < 3; g++) begin
            pb_n = 1'b0;
            repeat (glitch[g]) step();
            pb_n = 1'b1;
            repeat (6) step();
        end
        repeat (40) step();
        chk("t4 glitches ignored", obs_q.size(), 0);
        pb_n = 1'b0;
        repeat (DEB + 2) step();
        pb_n = 1'b1;
        expect_mask(3'b010);
        wait_done("t4 press", 1, 200);
        check_pulses("t4 press");
        pb_n = 1'b0;
        repeat (200) step();
        pb_n = 1'b1;
        repeat (10) step();
        expect_mask(3'b010);
        wait_done("t4 hold", 1, 200);
        check_pulses("t4 hold");

        // 5: reset mid-pulse with warm pending; request held across reset release
        ack_en = 0;
        issp_req = 3'b011;
        k = 0;
        while (f2h_cold_req_n && k < 50) begin
            step();
            k++;
        end
        chk("t5 cold asserted", f2h_cold_req_n, 0);
        step();
        issp_req = 3'b001;
        sys_reset = 1'b1;
        step();
        chk("t5 req_n released", {f2h_debug_req_n, f2h_warm_req_n, f2h_cold_req_n}, 3'b111);
        chk("t5 busy cleared", busy, 0);
        chk("t5 count cleared", req_count, 0);
        obs_q.delete();
        exp_q.delete();
        exp_count = 0;
        exp_cause = 0;
        step();
        sys_reset = 1'b0;
        repeat (60) step();
        chk("t5 no request after reset", obs_q.size(), 0);
        chk("t5 count still 0", req_count, 0);
        chk("t5 last_cause none", last_cause, 0);
        issp_req = 3'b000;
        step();

        // 6: debug requests saturate the counter; edge while busy is held
        ack_en = 1;
        for (int i = 0; i < 5; i++) begin
            issp_edge(3'b100);
            expect_mask(3'b100);
            wait_done("t6", 1, 200);
            check_pulses("t6");
        end
        issp_edge(3'b100);
        expect_mask(3'b100);
        k = 0;
        while (f2h_debug_req_n && k < 50) begin
            step();
            k++;
        end
        chk("t6 first debug asserted", f2h_debug_req_n, 0);
        step();
        issp_edge(3'b100);
        expect_mask(3'b100);
        wait_done("t6 busy edge", 2, 300);
        if (obs_q.size() >= 2) begin
            chk("t6 held edge served after holdoff", obs_q[1].start, obs_q[0].stop + HOLD + 1);
        end
        check_pulses("t6 busy edge");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
